// File: rtl/aclk_pkg.sv
// Shared definitions for the alarm-clock keypad controller: state encoding,
// idle key code and timeout default.
package aclk_pkg;

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  localparam logic [3:0]  NOKEY_DEFAULT       = 4'hA;
  localparam int unsigned TIMEOUT_SEC_DEFAULT = 10;
  localparam logic [2:0]  DIGITS_FULL         = 3'd4;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/aclk_timeout_cnt.sv
// Inactivity counter: counts one_second ticks while enabled and flags the
// tick that completes TIMEOUT_SEC seconds.
module aclk_timeout_cnt
  import aclk_pkg::*;
#(
  parameter int unsigned TIMEOUT_SEC = TIMEOUT_SEC_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT_SEC + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_SEC - 1);
  localparam logic [W-1:0] MAX  = W'(TIMEOUT_SEC);

  logic [W-1:0] count;

  // Saturating second counter; clear dominates counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && tick && (count != MAX)) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign expired = enable && tick && (count == LAST);

endmodule

// File: rtl/aclk_key_ctrl.sv
// Keypad entry controller for the alarm clock: collects four digits and
// loads them into the alarm register or the time counter.
module aclk_key_ctrl
  import aclk_pkg::*;
#(
  parameter int unsigned TIMEOUT_SEC = TIMEOUT_SEC_DEFAULT,
  parameter logic [3:0]  NOKEY       = NOKEY_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       shift,
  output logic       show_new_time,
  output logic       show_a,
  output logic       load_new_alarm,
  output logic       load_new_time
);

  state_t     state;
  state_t     next_state;
  logic [2:0] digit_cnt;
  logic       timeout;
  logic       in_entry;
  logic       cnt_clear;
  logic       digit;
  logic       full;

  assign digit    = is_digit(key) && (key != NOKEY);
  assign full     = (digit_cnt == DIGITS_FULL);
  assign in_entry = (state == KEY_WAITED) || (state == KEY_ENTRY);
  assign cnt_clear = (state == SHOW_TIME) || (state == SHOW_ALARM) ||
                     (state == SET_ALARM_TIME) || (state == SET_CURRENT_TIME);

  aclk_timeout_cnt #(
    .TIMEOUT_SEC (TIMEOUT_SEC)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (!in_entry),
    .enable  (in_entry),
    .tick    (one_second),
    .expired (timeout)
  );

  // Next-state decode; button checks precede digits so a completed entry
  // is committed before any further key is accepted.
  always_comb begin
    next_state = state;
    case (state)
      SHOW_TIME: begin
        if (alarm_button)  next_state = SHOW_ALARM;
        else if (digit)    next_state = KEY_STORED;
        else               next_state = SHOW_TIME;
      end
      SHOW_ALARM: begin
        if (!alarm_button) next_state = SHOW_TIME;
        else               next_state = SHOW_ALARM;
      end
      KEY_STORED: next_state = KEY_WAITED;
      KEY_WAITED: begin
        if (key == NOKEY)  next_state = KEY_ENTRY;
        else if (timeout)  next_state = SHOW_TIME;
        else               next_state = KEY_WAITED;
      end
      KEY_ENTRY: begin
        if (alarm_button && full)     next_state = SET_ALARM_TIME;
        else if (time_button && full) next_state = SET_CURRENT_TIME;
        else if (digit)               next_state = KEY_STORED;
        else if (timeout)             next_state = SHOW_TIME;
        else                          next_state = KEY_ENTRY;
      end
      SET_ALARM_TIME:   next_state = SHOW_TIME;
      SET_CURRENT_TIME: next_state = SHOW_TIME;
      default:          next_state = SHOW_TIME;
    endcase
  end

  // State register with outputs registered from the next state, so each
  // output is a pure function of the state it accompanies.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= SHOW_TIME;
      shift          <= 1'b0;
      show_new_time  <= 1'b0;
      show_a         <= 1'b0;
      load_new_alarm <= 1'b0;
      load_new_time  <= 1'b0;
    end else begin
      state          <= next_state;
      shift          <= (next_state == KEY_STORED);
      show_new_time  <= (next_state == KEY_STORED) || (next_state == KEY_WAITED) ||
                        (next_state == KEY_ENTRY);
      show_a         <= (next_state == SHOW_ALARM);
      load_new_alarm <= (next_state == SET_ALARM_TIME);
      load_new_time  <= (next_state == SET_CURRENT_TIME);
    end
  end

  // Digit counter; a press straight out of an idle state counts from zero
  // even if the stale count has not been cleared yet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_cnt <= 3'd0;
    end else if ((next_state == KEY_STORED) && (state != KEY_STORED)) begin
      if (cnt_clear)          digit_cnt <= 3'd1;
      else if (full)          digit_cnt <= DIGITS_FULL;
      else                    digit_cnt <= digit_cnt + 3'd1;
    end else if (cnt_clear) begin
      digit_cnt <= 3'd0;
    end else begin
      digit_cnt <= digit_cnt;
    end
  end

endmodule

// File: tb/tb_aclk_key_ctrl.sv
// Directed self-checking bench for aclk_key_ctrl with hand-computed
// expectations for each keypad scenario.
module tb_aclk_key_ctrl;
  import aclk_pkg::*;

  localparam logic [3:0] NK = 4'hA;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       one_second = 1'b0;
  logic [3:0] key = NK;
  logic       alarm_button = 1'b0;
  logic       time_button = 1'b0;
  logic       shift, show_new_time, show_a, load_new_alarm, load_new_time;

  int errors = 0;
  int checks = 0;

  aclk_key_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .one_second     (one_second),
    .key            (key),
    .alarm_button   (alarm_button),
    .time_button    (time_button),
    .shift          (shift),
    .show_new_time  (show_new_time),
    .show_a         (show_a),
    .load_new_alarm (load_new_alarm),
    .load_new_time  (load_new_time)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    key = NK; alarm_button = 1'b0; time_button = 1'b0; one_second = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Digit press followed by release; ends in KEY_ENTRY.
  task automatic press(input logic [3:0] d);
    key = d;
    step();
    key = NK;
    step();
    step();
  endtask

  task automatic pulse();
    one_second = 1'b1;
    step();
    one_second = 1'b0;
    step();
  endtask

  task automatic test_reset();
    checks++;
    if ({shift, show_new_time, show_a, load_new_alarm, load_new_time} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {shift, show_new_time, show_a, load_new_alarm, load_new_time});
    end
    checks++;
    if (dut.state !== SHOW_TIME) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state, SHOW_TIME);
    end
  endtask

  task automatic test_single_key();
    int shifts = 0;
    do_reset();
    key = 4'd5;
    step();
    checks++;
    if (shift !== 1'b1 || show_new_time !== 1'b1) begin
      errors++; $display("FAIL single_first: shift=%b snt=%b expected 1 1", shift, show_new_time);
    end
    shifts += int'(shift);
    step(); shifts += int'(shift);
    step(); shifts += int'(shift);
    key = NK;
    step(); shifts += int'(shift);
    checks++;
    if (shifts !== 1) begin
      errors++; $display("FAIL single_count: shifts=%0d expected 1", shifts);
    end
    checks++;
    if (show_new_time !== 1'b1 || dut.state !== KEY_ENTRY) begin
      errors++; $display("FAIL single_entry: snt=%b state=%0d expected 1 %0d",
                         show_new_time, dut.state, KEY_ENTRY);
    end
  endtask

  task automatic test_load_time();
    do_reset();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    time_button = 1'b1;
    step();
    time_button = 1'b0;
    checks++;
    if (load_new_time !== 1'b1 || load_new_alarm !== 1'b0 || show_new_time !== 1'b0) begin
      errors++; $display("FAIL load_time: lnt=%b lna=%b snt=%b expected 1 0 0",
                         load_new_time, load_new_alarm, show_new_time);
    end
    step();
    checks++;
    if (load_new_time !== 1'b0 || show_new_time !== 1'b0 || dut.state !== SHOW_TIME) begin
      errors++; $display("FAIL load_time_after: lnt=%b snt=%b state=%0d expected 0 0 %0d",
                         load_new_time, show_new_time, dut.state, SHOW_TIME);
    end
  endtask

  task automatic test_load_alarm();
    do_reset();
    press(4'd9); press(4'd8); press(4'd0); press(4'd6);
    alarm_button = 1'b1; time_button = 1'b1;
    step();
    alarm_button = 1'b0; time_button = 1'b0;
    checks++;
    if (load_new_alarm !== 1'b1 || load_new_time !== 1'b0) begin
      errors++; $display("FAIL load_alarm: lna=%b lnt=%b expected 1 0", load_new_alarm, load_new_time);
    end
    step();
    checks++;
    if (load_new_alarm !== 1'b0 || dut.state !== SHOW_TIME) begin
      errors++; $display("FAIL load_alarm_after: lna=%b state=%0d expected 0 %0d",
                         load_new_alarm, dut.state, SHOW_TIME);
    end
  endtask

  task automatic test_short_entry();
    do_reset();
    press(4'd0); press(4'd7);
    alarm_button = 1'b1;
    step();
    checks++;
    if (load_new_alarm !== 1'b0 || show_a !== 1'b0 || dut.state !== KEY_ENTRY) begin
      errors++; $display("FAIL short_alarm: lna=%b show_a=%b state=%0d expected 0 0 %0d",
                         load_new_alarm, show_a, dut.state, KEY_ENTRY);
    end
    alarm_button = 1'b0; time_button = 1'b1;
    step();
    time_button = 1'b0;
    checks++;
    if (load_new_time !== 1'b0 || dut.state !== KEY_ENTRY) begin
      errors++; $display("FAIL short_time: lnt=%b state=%0d expected 0 %0d",
                         load_new_time, dut.state, KEY_ENTRY);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    press(4'd3);
    for (int i = 0; i < 9; i++) pulse();
    checks++;
    if (dut.state !== KEY_ENTRY) begin
      errors++; $display("FAIL timeout_early: state=%0d expected %0d", dut.state, KEY_ENTRY);
    end
    one_second = 1'b1;
    step();
    one_second = 1'b0;
    checks++;
    if (dut.state !== SHOW_TIME || show_new_time !== 1'b0) begin
      errors++; $display("FAIL timeout_10th: state=%0d snt=%b expected %0d 0",
                         dut.state, show_new_time, SHOW_TIME);
    end
    // Digit on the same cycle as the 10th tick wins, and restarts the count.
    do_reset();
    press(4'd3);
    for (int i = 0; i < 9; i++) pulse();
    one_second = 1'b1; key = 4'd6;
    step();
    one_second = 1'b0; key = NK;
    checks++;
    if (shift !== 1'b1 || dut.state !== KEY_STORED) begin
      errors++; $display("FAIL timeout_digit: shift=%b state=%0d expected 1 %0d",
                         shift, dut.state, KEY_STORED);
    end
    step(); step();
    for (int i = 0; i < 9; i++) pulse();
    checks++;
    if (dut.state !== KEY_ENTRY) begin
      errors++; $display("FAIL timeout_restart: state=%0d expected %0d", dut.state, KEY_ENTRY);
    end
    pulse();
    checks++;
    if (dut.state !== SHOW_TIME) begin
      errors++; $display("FAIL timeout_restart_end: state=%0d expected %0d", dut.state, SHOW_TIME);
    end
  endtask

  task automatic test_nondigit();
    do_reset();
    key = 4'hF;
    step();
    checks++;
    if (shift !== 1'b0 || dut.state !== SHOW_TIME) begin
      errors++; $display("FAIL nondigit_idle: shift=%b state=%0d expected 0 %0d",
                         shift, dut.state, SHOW_TIME);
    end
    key = NK;
    step();
    press(4'd2);
    key = 4'hB;
    step();
    key = NK;
    checks++;
    if (shift !== 1'b0 || dut.state !== KEY_ENTRY) begin
      errors++; $display("FAIL nondigit_entry: shift=%b state=%0d expected 0 %0d",
                         shift, dut.state, KEY_ENTRY);
    end
  endtask

  task automatic test_alarm_hold();
    int bad = 0;
    do_reset();
    key = 4'd3; alarm_button = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (show_a !== 1'b1 || shift !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL alarm_hold: bad_cycles=%0d expected 0", bad);
    end
    alarm_button = 1'b0; key = NK;
    step();
    checks++;
    if (show_a !== 1'b0 || dut.state !== SHOW_TIME) begin
      errors++; $display("FAIL alarm_release: show_a=%b state=%0d expected 0 %0d",
                         show_a, dut.state, SHOW_TIME);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press(4'd1); press(4'd2);
    key = 4'd3;
    step();
    key = NK;
    step();
    checks++;
    if (dut.state !== KEY_WAITED) begin
      errors++; $display("FAIL mid_setup: state=%0d expected %0d", dut.state, KEY_WAITED);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({shift, show_new_time, show_a, load_new_alarm, load_new_time} !== 5'b00000 ||
        dut.state !== SHOW_TIME) begin
      errors++; $display("FAIL mid_reset: outs=%b state=%0d expected 00000 %0d",
                         {shift, show_new_time, show_a, load_new_alarm, load_new_time},
                         dut.state, SHOW_TIME);
    end
    step();
    reset = 1'b0;
    step();
    press(4'd4);
    time_button = 1'b1;
    step();
    time_button = 1'b0;
    checks++;
    if (load_new_time !== 1'b0 || dut.state !== KEY_ENTRY) begin
      errors++; $display("FAIL mid_noload: lnt=%b state=%0d expected 0 %0d",
                         load_new_time, dut.state, KEY_ENTRY);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_single_key();
    test_load_time();
    test_load_alarm();
    test_short_entry();
    test_timeout();
    test_nondigit();
    test_alarm_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
